// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants and the IF/ID pipeline record
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble insertion and hold
// Ports: clk, reset (sync, active-high), flush (load bubble), en (load d), d/q (ifid_t record).
module if_id_reg
    import riscv_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    input  logic  en,
    input  ifid_t d,
    output ifid_t q
);
    // reset and flush both load the bubble; flush beats a stall
    always_ff @(posedge clk)
        q <= (reset || flush) ? IFID_BUBBLE : en ? d : q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register of a 5-stage RV32 pipeline
// Ports: clk, reset (sync, active-high); StallF/StallD/FlushD hazard controls;
// PCSrcE/PCTargetE redirect from EX; InstrF from instruction memory at PCF;
// PCF fetch address; InstrD/PCD/PCPlus4D/ValidD decode-stage outputs;
// FetchCount/BubbleCount performance counters, live only with FETCH_PERF_COUNT_EN defined.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [XLEN-1:0] FetchCount,
    output logic [XLEN-1:0] BubbleCount
);
    logic [XLEN-1:0] pcf_plus4, pc_next;
    ifid_t ifid_d, ifid_q;
    logic unused_tgt_lsbs;

    // target low bits are dropped so PCF stays word aligned
    assign unused_tgt_lsbs = ^PCTargetE[1:0];
    assign pcf_plus4 = PCF + 32'd4;
    assign pc_next = PCSrcE ? {PCTargetE[XLEN-1:2], 2'b00} : StallF ? PCF : pcf_plus4;

    always_ff @(posedge clk)
        PCF <= reset ? {RESET_PC[XLEN-1:2], 2'b00} : pc_next;

    assign ifid_d = '{instr: InstrF, pc: PCF, pc_plus4: pcf_plus4, valid: 1'b1};

    if_id_reg u_if_id (
        .clk  (clk),
        .reset(reset),
        .flush(FlushD),
        .en   (!StallD),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

`ifdef FETCH_PERF_COUNT_EN
    logic [XLEN-1:0] fetch_cnt, bubble_cnt;
    logic load, bubble;
    assign bubble = FlushD || StallD;
    assign load = !bubble;
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (load && !(&fetch_cnt))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (bubble && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
    assign FetchCount  = fetch_cnt;
    assign BubbleCount = bubble_cnt;
`else
    assign FetchCount  = '0;
    assign BubbleCount = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven self-checking bench for fetch_stage
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE, InstrF, PCF, InstrD, PCD, PCPlus4D, FetchCount, BubbleCount;
    logic ValidD;
    logic [31:0] InstrF2, PCF2, InstrD2, PCD2, PCPlus4D2, FetchCount2, BubbleCount2;
    logic ValidD2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {8'hA5, a[25:2]};
    endfunction

    assign InstrF  = mem(PCF);
    assign InstrF2 = mem(PCF2);

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    fetch_stage #(.RESET_PC(32'h0000_1000)) dut2 (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF2), .PCF(PCF2),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2),
        .FetchCount(FetchCount2), .BubbleCount(BubbleCount2)
    );

    typedef struct {
        bit rst, sf, sd, fd, ps;
        logic [31:0] tgt;
        logic [31:0] e_pcf, e_pcd;
        bit e_v;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; StallF = v.sf; StallD = v.sd; FlushD = v.fd; PCSrcE = v.ps; PCTargetE = v.tgt;
    endtask

    initial begin
        int fc, bc;
        fc = 0;
        bc = 0;
        //               rst sf sd fd ps tgt           e_pcf          e_pcd          e_v
        vecs.push_back('{1, 0, 0, 0, 0, 32'h0,        32'h0,         32'h0,         0});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h4,         32'h0,         1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h8,         32'h4,         1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'hC,         32'h8,         1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h10,        32'hC,         1});
        vecs.push_back('{0, 1, 1, 0, 0, 32'h0,        32'h10,        32'hC,         1});
        vecs.push_back('{0, 1, 1, 0, 0, 32'h0,        32'h10,        32'hC,         1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h14,        32'h10,        1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h18,        32'h14,        1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h1C,        32'h18,        1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h20,        32'h1C,        1});
        vecs.push_back('{0, 0, 0, 1, 1, 32'h103,      32'h100,       32'h0,         0});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h104,       32'h100,       1});
        vecs.push_back('{0, 0, 1, 1, 0, 32'h0,        32'h108,       32'h0,         0});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h10C,       32'h108,       1});
        vecs.push_back('{0, 0, 1, 0, 0, 32'h0,        32'h110,       32'h108,       1});
        vecs.push_back('{0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h110,       1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h0,         32'hFFFF_FFFC, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h4,         32'h0,         1});
        vecs.push_back('{1, 1, 1, 0, 1, 32'h50,       32'h0,         32'h0,         0});
        vecs.push_back('{0, 0, 0, 0, 0, 32'h0,        32'h4,         32'h0,         1});

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
`ifdef FETCH_PERF_COUNT_EN
            if (vecs[i].rst) begin
                fc = 0;
                bc = 0;
            end else if (vecs[i].fd || vecs[i].sd) bc++;
            else fc++;
`endif
            chk($sformatf("v%0d PCF", i), PCF, vecs[i].e_pcf);
            chk($sformatf("v%0d PCD", i), PCD, vecs[i].e_pcd);
            chk($sformatf("v%0d ValidD", i), {31'b0, ValidD}, {31'b0, vecs[i].e_v});
            chk($sformatf("v%0d InstrD", i), InstrD, vecs[i].e_v ? mem(vecs[i].e_pcd) : NOP_INSTR);
            chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, vecs[i].e_v ? vecs[i].e_pcd + 32'd4 : 32'd0);
            chk($sformatf("v%0d FetchCount", i), FetchCount, 32'(fc));
            chk($sformatf("v%0d BubbleCount", i), BubbleCount, 32'(bc));
            if (i == 0) chk("rstpc PCF2", PCF2, 32'h0000_1000);
            if (i == 1) begin
                chk("rstpc PCD2", PCD2, 32'h0000_1000);
                chk("rstpc InstrD2", InstrD2, mem(32'h0000_1000));
                chk("rstpc PCF2 next", PCF2, 32'h0000_1004);
            end
        end

        // reset held across several edges while other controls toggle
        for (int k = 0; k < 3; k++) begin
            reset = 1'b1; StallF = k[0]; StallD = ~k[0]; FlushD = k[1]; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200 + 32'(k);
            @(posedge clk);
            #1;
            chk($sformatf("rsthold%0d PCF", k), PCF, 32'h0);
            chk($sformatf("rsthold%0d ValidD", k), {31'b0, ValidD}, 32'h0);
            chk($sformatf("rsthold%0d InstrD", k), InstrD, NOP_INSTR);
            chk($sformatf("rsthold%0d FetchCount", k), FetchCount, 32'h0);
        end
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        @(posedge clk);
        #1;
        chk("release ValidD", {31'b0, ValidD}, 32'h1);
        chk("release InstrD", InstrD, mem(32'h0));
        chk("release PCF", PCF, 32'h4);
        // load-use stall on the first valid instruction
        StallF = 1'b1; StallD = 1'b1;
        @(posedge clk);
        #1;
        chk("loaduse PCF", PCF, 32'h4);
        chk("loaduse InstrD", InstrD, mem(32'h0));
        StallF = 1'b0; StallD = 1'b0;
        @(posedge clk);
        #1;
        chk("loaduse release PCD", PCD, 32'h4);
        chk("loaduse release PCF", PCF, 32'h8);
`ifdef FETCH_PERF_COUNT_EN
        chk("loaduse FetchCount", FetchCount, 32'd2);
        chk("loaduse BubbleCount", BubbleCount, 32'd1);
`else
        chk("loaduse FetchCount", FetchCount, 32'd0);
        chk("loaduse BubbleCount", BubbleCount, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
